// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: data width, op-codes, FSM state type
// and the packed result-FIFO entry.
// Latency: n/a (types and constants only). Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // One result-FIFO entry as presented on the out_* ports.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              cout;
    logic              zero;
    logic              err;
  } entry_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU: AND, OR, ADD, SUB, signed SLT; unknown ops give 0.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: result/cout out; op, a, b in.
module alu_32bit
  import alu_pkg::*;
(
  output logic [DATA_W-1:0] result,
  output logic              cout,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b
);

  logic [DATA_W:0] sum;

  // SUB is a + ~b + 1 so the carry-out is the usual "no borrow" flag.
  always_comb begin
    if (op == OP_SUB) begin
      sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      sum = {1'b0, a} + {1'b0, b};
    end
  end

  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_SUB: begin
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        result = '0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-state FSM captures a command, evaluates it and pushes the result into a FIFO.
// Latency: accept at edge E -> push at E+1 (1 command per 2 cycles). Backpressure: a full FIFO
// holds the command in EXEC (in_ready=0) until a slot frees; a pop on the same edge frees one.
// Ports: clk/rst; in_valid/in_ready/in_op/in_a/in_b command side;
//        out_valid/out_ready/out_result/out_cout/out_zero/out_err/out_count FIFO head side.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_op,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_result,
  output logic                   out_cout,
  output logic                   out_zero,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  entry_t            push_ent;
  logic              accept, push, pop, full;

  alu_32bit u_alu (
    .result (alu_result),
    .cout   (alu_cout),
    .op     (op_q),
    .a      (a_q),
    .b      (b_q)
  );

  assign accept = in_valid && (state_q == IDLE);
  assign pop    = (count_q != '0) && out_ready;
  assign full   = (count_q == CW'(DEPTH));
  // A full FIFO still takes the push if the head leaves on the same edge.
  assign push   = (state_q == EXEC) && (!full || pop);

  // Illegal ops are still retired, flagged with err and a forced zero result.
  always_comb begin
    push_ent = '0;
    if (op_is_legal(op_q)) begin
      push_ent.result = alu_result;
      push_ent.cout   = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_cout : 1'b0;
      push_ent.zero   = (alu_result == '0);
      push_ent.err    = 1'b0;
    end else begin
      push_ent.result = '0;
      push_ent.cout   = 1'b0;
      push_ent.zero   = 1'b1;
      push_ent.err    = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
    end
  end

  // Storage is cleared on reset so the head payload reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (count_q != '0);
  assign out_count  = count_q;
  assign out_result = mem_q[rd_ptr_q].result;
  assign out_cout   = mem_q[rd_ptr_q].cout;
  assign out_zero   = mem_q[rd_ptr_q].zero;
  assign out_err    = mem_q[rd_ptr_q].err;

endmodule
